// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions, fetch states.
package cpu_pkg;

  // Opcodes that the fetch unit and the IR decode both need to recognise
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] OP_NOP  = 5'b11010;

  // Instruction field positions shared with the IR decode
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;
  localparam int C_HI   = 14;
  localparam int C_LO   = 0;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    FS_IDLE   = 3'd0,
    FS_REQ    = 3'd1,
    FS_LOAD   = 3'd2,
    FS_HOLD   = 3'd3,
    FS_HALTED = 3'd4
  } fetch_state_e;

  // Opcode field of an instruction word
  function automatic logic [4:0] get_opc(input logic [31:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads words from instruction memory,
// and presents each one to the IR with a single-cycle IRin strobe.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int          ADDR_W   = 9,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [4:0]  HALT_OP  = OP_HALT
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              Run,
  input  logic              Next,
  input  logic              PCload,
  input  logic [31:0]       PCin,
  output logic              MemRead,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemReady,
  input  logic [31:0]       MemData,
  output logic [31:0]       BusOut,
  output logic              IRin,
  output logic [31:0]       PC,
  output logic              Fetched,
  output logic              Halted
);

  localparam logic [2:0] S_IDLE   = FS_IDLE;
  localparam logic [2:0] S_REQ    = FS_REQ;
  localparam logic [2:0] S_LOAD   = FS_LOAD;
  localparam logic [2:0] S_HOLD   = FS_HOLD;
  localparam logic [2:0] S_HALTED = FS_HALTED;

  logic [2:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ibuf;
  logic        r_squash;

  logic [2:0]  w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_ibuf_nxt;
  logic        w_squash_nxt;

  // Next-state, PC, buffer and squash decisions for the fetch sequencer
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_ibuf_nxt   = r_ibuf;
    w_squash_nxt = r_squash;
    case (r_state)
      S_IDLE: begin
        if (Run) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
        if (PCload) begin
          w_pc_nxt = PCin;
        end else begin
          w_pc_nxt = r_pc;
        end
      end
      S_REQ: begin
        if (PCload) begin
          // A redirect kills the current request; if memory answered in the
          // same cycle that word is simply dropped, otherwise the eventual
          // answer is marked stale.
          w_pc_nxt     = PCin;
          w_squash_nxt = ~MemReady;
        end else if (MemReady) begin
          if (r_squash) begin
            w_squash_nxt = 1'b0;
          end else begin
            w_ibuf_nxt  = MemData;
            w_pc_nxt    = r_pc + 32'd1;
            w_state_nxt = S_LOAD;
          end
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_LOAD: begin
        if (get_opc(r_ibuf) == HALT_OP) begin
          w_state_nxt = S_HALTED;
        end else begin
          w_state_nxt = S_HOLD;
        end
        if (PCload) begin
          w_pc_nxt = PCin;
        end else begin
          w_pc_nxt = r_pc;
        end
      end
      S_HOLD: begin
        if (PCload) begin
          w_pc_nxt = PCin;
        end else begin
          w_pc_nxt = r_pc;
        end
        if (Next) begin
          w_state_nxt = Run ? S_REQ : S_IDLE;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HALTED: begin
        w_state_nxt = S_HALTED;
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_squash_nxt = 1'b0;
      end
    endcase
  end

  // Sequencer state registers with asynchronous clear
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_ibuf   <= 32'h0;
      r_squash <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_ibuf   <= w_ibuf_nxt;
      r_squash <= w_squash_nxt;
    end
  end

  // Outputs decode straight from registered state so a clear drops them at once
  assign MemRead = (r_state == S_REQ);
  assign MemAddr = MemRead ? r_pc[ADDR_W-1:0] : {ADDR_W{1'b0}};
  assign IRin    = (r_state == S_LOAD);
  assign BusOut  = IRin ? r_ibuf : 32'h0;
  assign Fetched = (r_state == S_LOAD) | (r_state == S_HOLD) | (r_state == S_HALTED);
  assign Halted  = (r_state == S_HALTED);
  assign PC      = r_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed sequences, a vector table of
// redirects, and a randomized run checked against a word-stream model.
module tb_instr_fetch;

  localparam int ADDR_W = 9;

  logic              Clock    = 1'b0;
  logic              Clear;
  logic              Run;
  logic              Next;
  logic              PCload;
  logic [31:0]       PCin;
  logic              MemRead;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemReady = 1'b0;
  logic [31:0]       MemData  = 32'h0;
  logic [31:0]       BusOut;
  logic              IRin;
  logic [31:0]       PC;
  logic              Fetched;
  logic              Halted;

  instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(32'h0), .HALT_OP(5'b11011)) dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .Next(Next), .PCload(PCload),
    .PCin(PCin), .MemRead(MemRead), .MemAddr(MemAddr), .MemReady(MemReady),
    .MemData(MemData), .BusOut(BusOut), .IRin(IRin), .PC(PC),
    .Fetched(Fetched), .Halted(Halted)
  );

  always #5 Clock = ~Clock;

  logic [31:0] mem [0:511];
  int  waits       = 0;
  bit  force_ready = 1'b0;
  int  wcnt        = 0;
  int  n_pass      = 0;
  int  n_total     = 0;

  // Memory model: answers a held request after 'waits' extra cycles
  always @(negedge Clock) begin
    if (force_ready) begin
      MemReady = 1'b1;
      MemData  = 32'hDEAD_BEEF;
      wcnt     = 0;
    end else if (MemRead) begin
      if (wcnt >= waits) begin
        MemReady = 1'b1;
        MemData  = mem[MemAddr];
        wcnt     = 0;
      end else begin
        MemReady = 1'b0;
        MemData  = 32'h0;
        wcnt     = wcnt + 1;
      end
    end else begin
      MemReady = 1'b0;
      MemData  = 32'h0;
      wcnt     = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic wait_irin(input string name);
    int k;
    k = 0;
    while (IRin !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk({name, "_irin_seen"}, 32'(IRin), 32'd1);
  endtask

  typedef struct {
    bit          do_load;
    logic [31:0] pcin;
    int          nwait;
    logic [8:0]  exp_addr;
    logic [31:0] exp_bus;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        vt [6];
  logic [31:0] m_pc;
  logic [31:0] w;
  logic [31:0] tgt;
  int          irin_cnt;
  int          good;
  int          bad;
  bit          got;
  bit          br;
  bit          stop;
  int          n;

  initial begin
    Clear = 1'b0; Run = 1'b1; Next = 1'b0; PCload = 1'b0; PCin = 32'h0;
    for (int a = 0; a < 512; a++) mem[a] = 32'h0880_0000 | 32'(a);
    mem[0] = 32'h0880_0005;

    vt[0] = '{1'b1, 32'h0000_01FF, 2, 9'h1FF, 32'h0880_01FF, 32'h0000_0200};
    vt[1] = '{1'b0, 32'h0,         1, 9'h000, 32'h0880_0005, 32'h0000_0201};
    vt[2] = '{1'b1, 32'h0000_1234, 0, 9'h034, 32'h0880_0034, 32'h0000_1235};
    vt[3] = '{1'b1, 32'hFFFF_FFFF, 0, 9'h1FF, 32'h0880_01FF, 32'h0000_0000};
    vt[4] = '{1'b0, 32'h0,         0, 9'h000, 32'h0880_0005, 32'h0000_0001};
    vt[5] = '{1'b0, 32'h0,         3, 9'h001, 32'h0880_0001, 32'h0000_0002};

    // Reset state
    repeat (2) tick();
    chk("rst_memread", 32'(MemRead), 32'd0);
    chk("rst_memaddr", 32'(MemAddr), 32'd0);
    chk("rst_irin",    32'(IRin),    32'd0);
    chk("rst_busout",  BusOut,       32'd0);
    chk("rst_fetched", 32'(Fetched), 32'd0);
    chk("rst_halted",  32'(Halted),  32'd0);
    chk("rst_pc",      PC,           32'd0);

    // First zero-wait fetch
    Clear = 1'b1;
    tick();
    chk("first_memread", 32'(MemRead), 32'd1);
    chk("first_memaddr", 32'(MemAddr), 32'd0);
    tick();
    chk("first_irin",    32'(IRin),    32'd1);
    chk("first_busout",  BusOut,       32'h0880_0005);
    chk("first_pc",      PC,           32'd1);
    chk("first_fetched", 32'(Fetched), 32'd1);
    tick();
    chk("hold_irin",    32'(IRin),    32'd0);
    chk("hold_busout",  BusOut,       32'd0);
    chk("hold_fetched", 32'(Fetched), 32'd1);

    // Three wait cycles: request held stable for four cycles, one delivery
    waits = 3; Next = 1'b1;
    tick();
    Next = 1'b0;
    good = 0; irin_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 4 && MemRead === 1'b1 && MemAddr === 9'd1) good++;
      if (IRin === 1'b1) irin_cnt++;
      if (i < 7) tick();
    end
    chk("wait_req_stable", 32'(good),     32'd4);
    chk("wait_irin_count", 32'(irin_cnt), 32'd1);
    chk("wait_pc",         PC,            32'd2);
    chk("wait_fetched",    32'(Fetched),  32'd1);

    // Redirect in REQ coinciding with the memory answer
    waits = 0; Next = 1'b1;
    tick();
    Next = 1'b0; PCload = 1'b1; PCin = 32'h40;
    tick();
    PCload = 1'b0;
    chk("sq_memread", 32'(MemRead), 32'd1);
    chk("sq_memaddr", 32'(MemAddr), 32'h40);
    chk("sq_no_irin", 32'(IRin),    32'd0);
    wait_irin("sq");
    chk("sq_busout", BusOut, 32'h0880_0040);
    chk("sq_pc",     PC,     32'h41);
    tick();

    // Vector table of redirects, truncation and PC wrap
    for (int v = 0; v < 6; v++) begin
      waits = vt[v].nwait;
      Next = 1'b1; PCload = vt[v].do_load; PCin = vt[v].pcin;
      tick();
      Next = 1'b0; PCload = 1'b0;
      chk($sformatf("vec%0d_memaddr", v), 32'(MemAddr), 32'(vt[v].exp_addr));
      wait_irin($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_busout", v), BusOut, vt[v].exp_bus);
      chk($sformatf("vec%0d_pc", v),     PC,     vt[v].exp_pc);
      tick();
    end

    // Randomized run against a word-stream model
    for (int a = 0; a < 512; a++) begin
      w = $urandom;
      if (w[31:27] == 5'b11011) w[31] = 1'b0;
      mem[a] = w;
    end
    m_pc = 32'h2;
    for (int it = 0; it < 150; it++) begin
      br    = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 5) == 0);
      tgt   = $urandom;
      waits = $urandom_range(0, 3);
      Next = 1'b1; PCload = br; PCin = tgt; Run = ~stop;
      if (br) m_pc = tgt;
      tick();
      Next = 1'b0; PCload = 1'b0;
      if (stop) begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
          chk("rnd_idle_noread", 32'(MemRead), 32'd0);
          if (i == n - 1) Run = 1'b1;
          tick();
        end
      end
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
        if (IRin === 1'b1) begin
          got = 1'b1;
        end else begin
          case ($urandom_range(0, 9))
            0: Next = 1'b1;
            1: begin
              tgt = $urandom; PCload = 1'b1; PCin = tgt; m_pc = tgt;
            end
            default: ;
          endcase
          tick();
          Next = 1'b0; PCload = 1'b0;
        end
      end
      chk("rnd_irin_seen", 32'(got),    32'd1);
      chk("rnd_busout",    BusOut,      mem[m_pc[8:0]]);
      chk("rnd_pc",        PC,          m_pc + 32'd1);
      m_pc = m_pc + 32'd1;
      if ($urandom_range(0, 9) == 0) begin
        tgt = $urandom; PCload = 1'b1; PCin = tgt; m_pc = tgt;
      end
      tick();
      PCload = 1'b0;
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        chk("rnd_hold_irin",    32'(IRin),    32'd0);
        chk("rnd_hold_fetched", 32'(Fetched), 32'd1);
        chk("rnd_hold_pc",      PC,           m_pc);
        if (i < n - 1) tick();
      end
    end

    // Halt opcode: delivered once, then nothing moves
    mem[9'h100] = 32'hD800_0000;
    waits = 0; Run = 1'b1;
    Next = 1'b1; PCload = 1'b1; PCin = 32'h100;
    tick();
    Next = 1'b0; PCload = 1'b0;
    wait_irin("halt");
    chk("halt_busout", BusOut, 32'hD800_0000);
    tick();
    chk("halt_halted",  32'(Halted),  32'd1);
    chk("halt_fetched", 32'(Fetched), 32'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      Next = 1'($urandom_range(0, 1)); PCload = 1'($urandom_range(0, 1));
      PCin = $urandom; Run = 1'($urandom_range(0, 1));
      tick();
      if (MemRead !== 1'b0 || IRin !== 1'b0 || Halted !== 1'b1 || Fetched !== 1'b1 || PC !== 32'h101)
        bad++;
    end
    chk("halt_absorbing", 32'(bad), 32'd0);
    Next = 1'b0; PCload = 1'b0; Run = 1'b1;

    // Clear during an outstanding request
    Clear = 1'b0;
    tick();
    waits = 5; Clear = 1'b1;
    tick();
    chk("clr_req_before", 32'(MemRead), 32'd1);
    #2 Clear = 1'b0;
    #1;
    chk("clr_memread", 32'(MemRead), 32'd0);
    chk("clr_memaddr", 32'(MemAddr), 32'd0);
    chk("clr_irin",    32'(IRin),    32'd0);
    chk("clr_busout",  BusOut,       32'd0);
    chk("clr_fetched", 32'(Fetched), 32'd0);
    chk("clr_halted",  32'(Halted),  32'd0);
    chk("clr_pc",      PC,           32'd0);
    tick();
    Run = 1'b0; force_ready = 1'b1;
    tick();
    Clear = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (MemRead !== 1'b0 || IRin !== 1'b0 || BusOut !== 32'h0) bad++;
    end
    chk("clr_idle_after", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
